// File: rtl/refill_pkg.sv
// Shared widths, types and FSM encoding for the miss/refill responder.
package refill_pkg;

    localparam int ADDR_W          = 15;
    localparam int DATA_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = 2;
    localparam int MEM_DEPTH       = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } refill_state_t;

endpackage

// File: rtl/refill_mem_array.sv
// 32K x 32 backing store: one synchronous preload write port, one read port.
// A read and a write to the same word at the same edge sample the old contents.
module refill_mem_array
    import refill_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  word_t             wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output word_t             rd_data_o
);

    word_t mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/miss_refill_server.sv
// Miss/refill responder: fetches the 4-word block around a missed address and
// strobes it into the cache. CRITICAL_WORD_FIRST_EN starts at the missed word.
module miss_refill_server
    import refill_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              fill_write,
    output logic [ADDR_W-1:0] fill_addr,
    output word_t             block_data [WORDS_PER_BLOCK],
    output logic              busy,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  word_t             ld_data,
    output logic [CNT_W-1:0]  refill_count,
    output logic              crit_valid,
    output word_t             crit_data
);

    localparam int WAIT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LATENCY);

    refill_state_t        state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [OFFSET_W-1:0]  beat_q, beat_d;
    logic [OFFSET_W-1:0]  word_sel;
    logic [ADDR_W-1:0]    fill_addr_q, fill_addr_d;
    word_t                block_q [WORDS_PER_BLOCK];
    word_t                block_d [WORDS_PER_BLOCK];
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADDR_W-1:0]    rd_addr;
    word_t                rd_data;

`ifdef CRITICAL_WORD_FIRST_EN
    logic  crit_valid_q, crit_valid_d;
    word_t crit_data_q, crit_data_d;

    assign word_sel = fill_addr_q[OFFSET_W-1:0] + beat_q;
`else
    assign word_sel = beat_q;
`endif

    // Block base ignores the low offset bits, so refills never wrap out of the block.
    assign rd_addr = {fill_addr_q[ADDR_W-1:OFFSET_W], word_sel};

    refill_mem_array u_mem (
        .clk       (clk),
        .wr_en_i   (ld_en),
        .wr_addr_i (ld_addr),
        .wr_data_i (ld_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            beat_q      <= '0;
            fill_addr_q <= '0;
            count_q     <= '0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                block_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            fill_addr_q <= fill_addr_d;
            count_q     <= count_d;
            block_q     <= block_d;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        fill_addr_d = fill_addr_q;
        count_d     = count_q;
        block_d     = block_q;
`ifdef CRITICAL_WORD_FIRST_EN
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    fill_addr_d = req_addr;
                    beat_d      = '0;
                    wait_d      = WAIT_INIT;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    block_d[word_sel] = rd_data;
`ifdef CRITICAL_WORD_FIRST_EN
                    if (beat_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = rd_data;
                    end
`endif
                    if (beat_q == OFFSET_W'(WORDS_PER_BLOCK - 1)) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + OFFSET_W'(1);
                        wait_d = WAIT_INIT;
                    end
                end
            end
            DONE: begin
                count_d = count_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready    = rst && (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign fill_write   = (state_q == DONE);
    assign fill_addr    = fill_addr_q;
    assign block_data   = block_q;
    assign refill_count = count_q;

`ifdef CRITICAL_WORD_FIRST_EN
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_miss_refill_server.sv
// Directed bench for miss_refill_server: a refill vector table plus hand-built
// sequences for back-to-back requests, preload collisions, reset and zero latency.
module tb_miss_refill_server;
    import refill_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_valid0;
    logic [14:0] req_addr, req_addr0;
    logic        ld_en;
    logic [14:0] ld_addr;
    logic [31:0] ld_data;

    logic        req_ready, fill_write, busy, crit_valid;
    logic [14:0] fill_addr;
    logic [31:0] block_data [4];
    logic [15:0] refill_count;
    logic [31:0] crit_data;

    logic        req_ready0, fill_write0, busy0, crit_valid0;
    logic [14:0] fill_addr0;
    logic [31:0] block_data0 [4];
    logic [1:0]  refill_count0;
    logic [31:0] crit_data0;

    always #5 clk = ~clk;

    miss_refill_server #(.MEM_LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .fill_write(fill_write), .fill_addr(fill_addr),
        .block_data(block_data), .busy(busy), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .refill_count(refill_count), .crit_valid(crit_valid),
        .crit_data(crit_data)
    );

    miss_refill_server #(.MEM_LATENCY(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_addr(req_addr0),
        .req_ready(req_ready0), .fill_write(fill_write0), .fill_addr(fill_addr0),
        .block_data(block_data0), .busy(busy0), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .refill_count(refill_count0), .crit_valid(crit_valid0),
        .crit_data(crit_data0)
    );

    typedef struct packed {
        logic [14:0]      addr;
        logic [3:0][31:0] d;
    } vec_t;

    vec_t vecs [6];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic [14:0] a, logic [31:0] w0, logic [31:0] w1,
                                logic [31:0] w2, logic [31:0] w3);
        vec_t v;
        v.addr = a;
        v.d[0] = w0;
        v.d[1] = w1;
        v.d[2] = w2;
        v.d[3] = w3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [14:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic chk_block(input string tag, input logic [3:0][31:0] exp);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_blk%0d", tag, i), block_data[i], exp[i]);
        end
    endtask

    // Edge 0 is the accepting edge; a preload is written at edge ld_edge (none if < 0).
    task automatic run_refill(input logic [14:0] a, input int ld_edge,
                              input logic [14:0] la, input logic [31:0] ldd,
                              output int fw, output int ce, output int cn,
                              output logic [31:0] cw);
        fw = -1; ce = -1; cn = 0; cw = '0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int e = 0; e < 200; e++) begin
            ld_en   = (e == ld_edge);
            ld_addr = la;
            ld_data = ldd;
            tick();
            if (e == 0) req_valid = 1'b0;
            if (crit_valid) begin
                cn++;
                if (ce < 0) begin
                    ce = e;
                    cw = crit_data;
                end
            end
            if (fill_write) begin
                fw = e;
                break;
            end
        end
        ld_en = 1'b0;
    endtask

    task automatic run0(input logic [14:0] a, output int fw, output logic rdy);
        fw  = -1;
        rdy = 1'b0;
        req_valid0 = 1'b1;
        req_addr0  = a;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (e == 0) req_valid0 = 1'b0;
            if (fw >= 0) begin
                rdy = req_ready0;
                break;
            end
            if (fill_write0) fw = e;
        end
    endtask

    initial begin
        int          fw, ce, cn, fw1, fw2, seen;
        logic [31:0] cw;
        logic        rdy;
        logic [3:0][31:0] exp_blk;

        req_valid = 0; req_addr = '0; req_valid0 = 0; req_addr0 = '0;
        ld_en = 0; ld_addr = '0; ld_data = '0;

        vecs[0] = mk(15'h1231, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vecs[1] = mk(15'h0004, 32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003);
        vecs[2] = mk(15'h7FFF, 32'hC0DE_7FFC, 32'hC0DE_7FFD, 32'hC0DE_7FFE, 32'hC0DE_7FFF);
        vecs[3] = mk(15'h0102, 32'h0B0B_0100, 32'h0B0B_0101, 32'h0B0B_0102, 32'h0B0B_0103);
        vecs[4] = mk(15'h0040, 32'h40, 32'h41, 32'h42, 32'h43);
        vecs[5] = mk(15'h0003, 32'h55, 32'h66, 32'h77, 32'h88);

        // Reset values
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_fill_write", 32'(fill_write), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fill_addr", 32'(fill_addr), 32'h0);
        chk("rst_count", 32'(refill_count), 32'h0);
        chk("rst_crit_valid", 32'(crit_valid), 32'h0);
        chk("rst_crit_data", crit_data, 32'h0);
        chk_block("rst", '0);
        rst = 1'b1;
        tick();
        chk("idle_req_ready", 32'(req_ready), 32'h1);

        for (int v = 0; v < 6; v++) begin
            for (int w = 0; w < 4; w++) begin
                preload({vecs[v].addr[14:2], 2'(w)}, vecs[v].d[w]);
            end
        end

        for (int v = 0; v < 6; v++) begin
            run_refill(vecs[v].addr, -1, '0, '0, fw, ce, cn, cw);
            chk($sformatf("v%0d_fw_edge", v), fw, 4 * (LAT + 1));
            chk($sformatf("v%0d_fill_addr", v), 32'(fill_addr), 32'(vecs[v].addr));
            chk_block($sformatf("v%0d", v), vecs[v].d);
`ifdef CRITICAL_WORD_FIRST_EN
            chk($sformatf("v%0d_crit_edge", v), ce, LAT + 1);
            chk($sformatf("v%0d_crit_pulses", v), cn, 1);
            chk($sformatf("v%0d_crit_data", v), cw, vecs[v].d[vecs[v].addr[1:0]]);
`else
            chk($sformatf("v%0d_crit_pulses", v), cn, 0);
            chk($sformatf("v%0d_crit_data", v), crit_data, 32'h0);
`endif
            tick();
            chk($sformatf("v%0d_fw_one_cycle", v), 32'(fill_write), 32'h0);
            chk($sformatf("v%0d_ready_back", v), 32'(req_ready), 32'h1);
            chk($sformatf("v%0d_count", v), 32'(refill_count), v + 1);
        end

        // Busy rejection and back-to-back acceptance
        fw1 = -1; fw2 = -1;
        req_valid = 1'b1;
        req_addr  = 15'h0004;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (e == 0) req_addr = 15'h7FFE;
            if (fill_write) begin
                if (fw1 < 0) fw1 = e;
                else begin
                    fw2 = e;
                    break;
                end
            end
            if (e == 13) begin
                chk("b2b_hold_addr", 32'(fill_addr), 32'h0004);
                chk("b2b_ready_idle", 32'(req_ready), 32'h1);
                chk_block("b2b_first", vecs[1].d);
            end
            if (e == 14) begin
                chk("b2b_accept_busy", 32'(busy), 32'h1);
                chk("b2b_accept_addr", 32'(fill_addr), 32'h7FFE);
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("b2b_fw1_edge", fw1, 12);
        chk("b2b_fw2_edge", fw2, 26);
        chk_block("b2b_second", vecs[2].d);
        tick();
        chk("b2b_count", 32'(refill_count), 32'd8);

        // Preload racing the beat reads
        exp_blk = vecs[4].d;
        run_refill(15'h0040, 10, 15'h0043, 32'hDEAD, fw, ce, cn, cw);
        exp_blk[3] = 32'hDEAD;
        chk("col_early_fw", fw, 12);
        chk_block("col_early", exp_blk);
        tick();
        run_refill(15'h0040, 12, 15'h0043, 32'hBEEF, fw, ce, cn, cw);
        chk_block("col_same_edge", exp_blk);
        tick();
        run_refill(15'h0040, -1, '0, '0, fw, ce, cn, cw);
        exp_blk[3] = 32'hBEEF;
        chk_block("col_after", exp_blk);
        tick();
        chk("col_count", 32'(refill_count), 32'd11);

        // Reset during beat 2
        seen = 0;
        req_valid = 1'b1;
        req_addr  = 15'h1231;
        for (int e = 0; e < 9; e++) begin
            tick();
            if (e == 0) req_valid = 1'b0;
            if (fill_write) seen++;
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_fill_addr", 32'(fill_addr), 32'h0);
        chk("mid_rst_count", 32'(refill_count), 32'h0);
        chk("mid_rst_crit", 32'(crit_valid), 32'h0);
        chk_block("mid_rst", '0);
        for (int e = 0; e < 3; e++) begin
            tick();
            if (fill_write) seen++;
        end
        chk("mid_rst_no_fw", seen, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        run_refill(15'h1231, -1, '0, '0, fw, ce, cn, cw);
        chk("post_rst_fw", fw, 12);
        chk_block("post_rst", vecs[0].d);
        tick();
        chk("post_rst_count", 32'(refill_count), 32'h1);

        // Zero wait states and a 2-bit counter that wraps
        for (int k = 0; k < 5; k++) begin
            run0(15'h0000, fw, rdy);
            chk($sformatf("lat0_%0d_fw", k), fw, 4);
            chk($sformatf("lat0_%0d_ready", k), 32'(rdy), 32'h1);
            chk($sformatf("lat0_%0d_count", k), 32'(refill_count0), (k + 1) % 4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("lat0_%0d_blk%0d", k, i), block_data0[i], vecs[5].d[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/miss_refill_server.md
Name: miss_refill_server

Overview:
- Responder side of the cache miss/refill interface. Owns the 32K-word backing memory.
- On a miss request it fetches the 4-word block containing the missed address, one word per beat, with configurable wait states.
- It then presents the assembled block on a 4-entry array and pulses a one-cycle write strobe that drives the cache's block-write input.
- A preload port lets the bench or boot logic initialise memory contents.

Parameters:
- MEM_LATENCY, 2, wait cycles inserted before each word read (0 allowed: 1 cycle per beat).
- CNT_W, 16, width of the completed-refill counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  miss request from cache controller.
- req_addr  in  15  word address that missed.
- req_ready  out  1  server idle, request can be accepted.
- fill_write  out  1  one-cycle strobe, connects to the cache block-write input.
- fill_addr  out  15  latched req_addr, unmodified; the cache derives index and tag itself.
- block_data  out  32 x [0:3]  refill block; entry i = mem[{fill_addr[14:2], i}].
- busy  out  1  refill in progress (not IDLE).
- ld_en  in  1  preload write enable.
- ld_addr  in  15  preload word address.
- ld_data  in  32  preload data.
- refill_count  out  CNT_W  completed refills, wraps modulo 2^CNT_W.
- crit_valid  out  1  critical word available (feature only, else 0).
- crit_data  out  32  critical word (feature only, else 0).

Behaviour:
- Reset values (rst low, asynchronous):
  - req_ready=0 while rst is low, then 1 in IDLE.
  - fill_write=0, busy=0, fill_addr=0, all block_data entries=0, refill_count=0, crit_valid=0, crit_data=0.
  - Memory array is NOT cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch req_addr into fill_addr, clear beat index to 0, wait counter to MEM_LATENCY, go to FETCH.
  - FETCH: if wait counter != 0, decrement it. Else read mem[{fill_addr[14:2], beat}] into block_data[beat]. If beat==3 go to DONE; otherwise increment beat and reload the wait counter.
  - DONE: fill_write=1 for exactly this cycle; increment refill_count; go to IDLE.
- Timing, with the accepting edge as edge 0:
  - fill_write is high from edge 4*(MEM_LATENCY+1) to the next edge.
  - req_ready returns at edge 4*(MEM_LATENCY+1)+1.
- Handshake:
  - req_ready=0 outside IDLE; req_valid in those cycles is ignored. The requester holds req_valid and req_addr until it is accepted.
  - Back-to-back requests: a request held through DONE is accepted on the first IDLE edge.
- block_data and fill_addr change only while refilling. They hold their values after DONE until the next beat writes them.
- Preload:
  - ld_en is accepted in every state; it writes mem[ld_addr]=ld_data at the edge.
  - A read and write to the same address at the same edge returns the OLD value. A later beat sees the new value.
- Addressing: block base is always fill_addr[14:2] with low bits 00. No wrap past the block; address 0x7FFF refills 0x7FFC..0x7FFF.
- Reset mid-refill: abort immediately; no fill_write; state returns to IDLE.
- refill_count wraps from all-ones to 0.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - Beats fetch in order (req_addr[1:0] + k) mod 4, for k = 0..3.
  - crit_valid pulses for one cycle at the edge the first beat completes, with crit_data = that word.
  - Final block_data and fill_write timing are unchanged.
- Undefined:
  - Beats fetch 0,1,2,3.
  - crit_valid and crit_data are tied to 0.

Decomposition:
- Package refill_pkg:
  - ADDR_W=15, DATA_W=32, WORDS_PER_BLOCK=4, OFFSET_W=2.
  - refill_state_t enum {IDLE, FETCH, DONE}.
  - word_t typedef.
- Sub-module refill_mem_array: 32768x32 memory, one synchronous write port (preload) and one read port. It implements old-data-on-collision; the FSM lives in the top.

Test Plan:
- Reset and single refill:
  - Preload mem[0x1230..0x1233] = 0xA0..0xA3, MEM_LATENCY=2.
  - Request addr 0x1231 → fill_write high exactly at edge 12; block_data = {A0,A1,A2,A3}; fill_addr=0x1231; refill_count=1.
- Busy rejection: while refilling 0x0004, drive req_valid with 0x7FFE → ignored until IDLE. Held request is accepted one edge after DONE; the second block is 0x7FFC..0x7FFF.
- Latency zero: MEM_LATENCY=0, request 0x0000 → fill_write at edge 4; req_ready at edge 5.
- Preload collision: during a refill of 0x0040, write mem[0x0043]=0xDEAD before beat 3 → block_data[3]=0xDEAD. A write at the same edge as the beat-3 read → old value returned.
- Reset mid-refill: assert rst during beat 2 → no fill_write; all outputs return to reset values. The next request completes normally and memory retains its preload.
- CRITICAL_WORD_FIRST_EN defined, request 0x0102 → crit_valid at edge MEM_LATENCY+1 with crit_data=mem[0x0102]; final block is in index order.
